// File: rtl/register_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
//   ISA_WIDTH        default data width of every register
//   RF_AW            register address width
//   RF_NREGS_DEFAULT default number of architectural registers
//   RF_NRD_DEFAULT   default number of read ports
package register_file_mp_pkg;

    localparam int ISA_WIDTH        = 32;
    localparam int RF_AW            = 5;
    localparam int RF_NREGS_DEFAULT = 32;
    localparam int RF_NRD_DEFAULT   = 2;

    typedef logic [RF_AW-1:0] rf_addr_t;

    // True for a real, writable register: not x0 and inside the implemented range.
    function automatic logic addr_ok(input rf_addr_t a, input int nregs);
        return (a != '0) && (int'(a) < nregs);
    endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst_n   clock, asynchronous active-low reset
//   rsv, rsv_a   reserve request from issue (marks rsv_a busy)
//   we, wa       writeback (clears wa busy)
//   busy         registered scoreboard vector, bit 0 always 0
//   busy_next    scoreboard value after the current edge
module rf_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rsv,
    input  rf_addr_t         rsv_a,
    input  logic             we,
    input  rf_addr_t         wa,
    output logic [NREGS-1:0] busy,
    output logic [NREGS-1:0] busy_next
);

    // Reserve beats writeback: a writeback landing in the same cycle as a
    // new reservation belongs to the older producer, so the register stays busy.
    // Addresses at or above NREGS never match any r and are ignored naturally.
    always_comb begin
        busy_next    = busy;
        busy_next[0] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (rsv && (rsv_a == rf_addr_t'(r))) begin
                busy_next[r] = 1'b1;
            end else if (we && (wa == rf_addr_t'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Register file with NRD registered read ports, one write port with
// write-first bypass, and a per-register busy scoreboard. x0 reads as zero.
//   clk, rst_n   clock, asynchronous active-low reset
//   ra, re       packed read addresses (5 bits per port) and per-port enables
//   rdata, rbusy packed registered read data and busy flags per port
//   we, wa, wdata write port
//   rsv, rsv_a   scoreboard reserve request
//   busy         current scoreboard vector
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int XLEN  = ISA_WIDTH,
    parameter int NREGS = RF_NREGS_DEFAULT,
    parameter int NRD   = RF_NRD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*RF_AW-1:0] ra,
    input  logic [NRD-1:0]      re,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [RF_AW-1:0]    wa,
    input  logic [XLEN-1:0]     wdata,
    input  logic                rsv,
    input  logic [RF_AW-1:0]    rsv_a,
    output logic [NREGS-1:0]    busy
);

    localparam int IW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_next;
    logic             wr_ok;

    assign wr_ok = we && addr_ok(wa, NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wa[IW-1:0]] <= wdata;
        end
    end

    rf_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv      (rsv),
        .rsv_a    (rsv_a),
        .we       (we),
        .wa       (wa),
        .busy     (busy),
        .busy_next(busy_next)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_addr_t        a;
        logic            a_ok;
        logic [XLEN-1:0] rd_q;
        logic            rb_q;

        assign a    = ra[k*RF_AW +: RF_AW];
        assign a_ok = addr_ok(a, NREGS);

        // wr_ok already excludes x0 and out-of-range, so the bypass can only
        // hit a real register; rbusy samples busy_next to line up with it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
                rb_q <= 1'b0;
            end else if (re[k]) begin
                if (!a_ok) begin
                    rd_q <= '0;
                    rb_q <= 1'b0;
                end else begin
                    rd_q <= (wr_ok && (wa == a)) ? wdata : regs[a[IW-1:0]];
                    rb_q <= busy_next[a[IW-1:0]];
                end
            end
        end

        assign rdata[k*XLEN +: XLEN] = rd_q;
        assign rbusy[k]              = rb_q;
    end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ra;
    logic [1:0]  re;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wdata;
    logic        rsv;
    logic [4:0]  rsv_a;

    logic [63:0] rdata, rdata16;
    logic [1:0]  rbusy, rbusy16;
    logic [31:0] busy;
    logic [15:0] busy16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .re(re), .rdata(rdata), .rbusy(rbusy),
        .we(we), .wa(wa), .wdata(wdata), .rsv(rsv), .rsv_a(rsv_a), .busy(busy)
    );

    register_file_mp #(.XLEN(32), .NREGS(16), .NRD(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .ra(ra), .re(re), .rdata(rdata16), .rbusy(rbusy16),
        .we(we), .wa(wa), .wdata(wdata), .rsv(rsv), .rsv_a(rsv_a), .busy(busy16)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  rsv_a;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_rb0;
        logic        e_rb1;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic r, input logic [4:0] ra_, input logic [1:0] en,
                         input logic [4:0] a0, input logic [4:0] a1);
        we = w; wa = a; wdata = d; rsv = r; rsv_a = ra_; re = en; ra = {a1, a0};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  2'b00, 5'd5,  5'd0,
                    32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b01, 5'd5,  5'd0,
                    32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  2'b11, 5'd0,  5'd0,
                    32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  2'b01, 5'd7,  5'd0,
                    32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd7,  5'd7,
                    32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  2'b00, 5'd0,  5'd0,
                    32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h8};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b01, 5'd3,  5'd0,
                    32'h0,        32'hA5A5A5A5, 1'b1, 1'b0, 32'h8};
        tbl[7]  = '{1'b1, 5'd3,  32'h1,        1'b0, 5'd0,  2'b10, 5'd0,  5'd3,
                    32'h0,        32'h1,        1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd4,  2'b11, 5'd4,  5'd5,
                    32'h44,       32'hDEADBEEF, 1'b1, 1'b0, 32'h10};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  2'b01, 5'd3,  5'd0,
                    32'h1,        32'hDEADBEEF, 1'b1, 1'b0, 32'h18};
        tbl[10] = '{1'b1, 5'd4,  32'h55,       1'b1, 5'd0,  2'b10, 5'd0,  5'd4,
                    32'h1,        32'h55,       1'b1, 1'b0, 32'h8};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 2'b01, 5'd31, 5'd0,
                    32'h0,        32'h55,       1'b1, 1'b0, 32'h80000008};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc();
        cyc();
        chk("reset_rdata", rdata[31:0] | rdata[63:32], 32'h0);
        chk("reset_busy", busy, 32'h0);
        chk("reset_rbusy", 32'(rbusy), 32'h0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rsv, tbl[i].rsv_a,
                  tbl[i].re, tbl[i].ra0, tbl[i].ra1);
            cyc();
            chk($sformatf("v%0d_rd0", i), rdata[31:0], tbl[i].e_rd0);
            chk($sformatf("v%0d_rd1", i), rdata[63:32], tbl[i].e_rd1);
            chk($sformatf("v%0d_rb0", i), 32'(rbusy[0]), 32'(tbl[i].e_rb0));
            chk($sformatf("v%0d_rb1", i), 32'(rbusy[1]), 32'(tbl[i].e_rb1));
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_busy16", i), 32'(busy16), {16'h0, tbl[i].e_busy[15:0]});
        end

        // Out-of-range register on the 16-entry build; the 32-entry build accepts it.
        drive(1'b1, 5'd20, 32'hFF, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd20, 5'd20);
        cyc();
        chk("n16_rd0_x20", rdata16[31:0], 32'h0);
        chk("n16_rd1_x20", rdata16[63:32], 32'h0);
        chk("n32_rd0_x20", rdata[31:0], 32'hFF);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 2'b00, 5'd0, 5'd0);
        cyc();
        chk("n16_busy_rsv20", 32'(busy16), 32'h8);
        chk("n32_busy_rsv20", busy, 32'h80100008);

        // Load x1..x3, reserve x2, then reset asynchronously between edges.
        drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        cyc();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd2, 2'b00, 5'd0, 5'd0);
        cyc();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 2'b11, 5'd1, 5'd2);
        cyc();
        chk("pre_rst_rd0", rdata[31:0], 32'h11);
        chk("pre_rst_rb1", 32'(rbusy[1]), 32'h1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rdata", rdata[31:0] | rdata[63:32], 32'h0);
        chk("async_rst_rbusy", 32'(rbusy), 32'h0);
        chk("async_rst_busy", busy, 32'h0);
        chk("async_rst_busy16", 32'(busy16), 32'h0);
        cyc();
        #2 rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd1, 5'd2);
        cyc();
        chk("post_rst_x1", rdata[31:0], 32'h0);
        chk("post_rst_x2", rdata[63:32], 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b01, 5'd3, 5'd0);
        cyc();
        chk("post_rst_x3", rdata[31:0], 32'h0);
        chk("post_rst_busy", busy, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the single-port register file: NREGS general registers of XLEN bits, x0 hardwired to zero.
- Provides NRD independent registered read ports, one write port with write-first bypass, and a per-register busy scoreboard.
- The issue stage uses the scoreboard to detect RAW hazards.
- Sits between decode/issue (read addresses, reserve) and writeback (write port).

Parameters:
- XLEN, `ISA_WIDTH (32), data width of every register and read port.
- NREGS, 32, number of architectural registers; legal values 16 (RV32E) or 32.
- NRD, 2, number of read ports; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  NRD*5  packed read addresses; port k uses bits [5k+4:5k].
- re  in  NRD  per-port read enable.
- rdata  out  NRD*XLEN  packed registered read data; port k uses bits [k*XLEN+XLEN-1:k*XLEN].
- rbusy  out  NRD  registered busy flag of the register read on port k.
- we  in  1  write enable.
- wa  in  5  write address.
- wdata  in  XLEN  write data.
- rsv  in  1  reserve request from issue.
- rsv_a  in  5  register to mark busy.
- busy  out  NREGS  current scoreboard vector; bit 0 is always 0.

Behaviour:
- Reset (rst_n low, asynchronous): all registers, rdata, rbusy and busy are cleared to 0.
- Write at posedge: if we=1, wa≠0 and wa<NREGS, then regs[wa] <= wdata. All other writes are dropped silently.
- Read at posedge, per port k with re[k]=1 (1-cycle latency):
  - ra_k=0 or ra_k≥NREGS → 0.
  - else, if we=1 and wa=ra_k → wdata (write-first bypass).
  - else → regs[ra_k].
- Read with re[k]=0: rdata_k and rbusy_k hold their previous values.
- Multiple ports may read the same address in the same cycle; each returns an identical value.
- Scoreboard next-state, computed per register r≥1:
  - set if rsv=1 and rsv_a=r.
  - else clear if we=1 and wa=r.
  - else hold.
  - Simultaneous reserve and write to the same register: reserve wins, so busy stays 1 (a new producer was issued).
  - Reserve to x0 or to an address ≥NREGS is ignored.
  - busy[0] is always 0.
- rbusy_k <= busy_next[ra_k] when re[k]=1. The flag reflects the scoreboard after this edge's update, consistent with the bypassed rdata.
- Reset mid-operation: in-flight reads are discarded, outputs return to 0, and every busy bit is cleared.
- No combinational path from any input to any output. busy is driven directly from flops.

Decomposition:
- conf.v additions:
  - `RF_AW (5).
  - `RF_NREGS_DEFAULT (32).
  - `RF_NRD_DEFAULT (2).
- XLEN keeps defaulting to `ISA_WIDTH.
- Sub-module rf_scoreboard holds the NREGS busy flops, the set/clear priority logic and the busy_next output.
- register_file_mp instantiates rf_scoreboard once, plus a generate loop over the NRD read ports.

Test Plan:
1. Reset, then write x5=0xDEADBEEF, then read ra0=5 with re0=1 on the next cycle → rdata0=0xDEADBEEF one cycle later; rdata1 stays 0.
2. Write x0=0x12345678, then read x0 on both ports → both return 0; busy[0] stays 0.
3. Same-cycle write x7=0xA5A5A5A5 while port 0 reads x7 → rdata0=0xA5A5A5A5 after one edge (bypass). A later read of x7 also returns 0xA5A5A5A5.
4. Scoreboard sequence:
   - rsv x3 → busy[3]=1.
   - Read x3 → rbusy0=1.
   - we x3=0x1 → busy[3]=0.
   - Simultaneous rsv x4 and we x4 → busy[4]=1.
5. NREGS=16 build: write x20=0xFF → dropped. Read x20 → 0. rsv x20 → busy unchanged.
6. Load x1..x3 with nonzero values and rsv x2, then assert rst_n low mid-cycle → rdata=0, rbusy=0 and busy=0 immediately (asynchronous). After release, x1..x3 read back as 0.
